// File: rtl/fp_pkg.sv
// Shared constants for the FPU round/pack stage: default widths, rounding modes,
// canonical NaN and flag bit positions.
package fp_pkg;

    localparam int DEF_EXP_W = 11;
    localparam int DEF_MAN_W = 53;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RUP = 2'b10;
    localparam logic [1:0] RM_RDN = 2'b11;

    localparam logic [63:0] CANON_NAN = 64'h7FF8_0000_0000_0000;

    // out_flags = {overflow, underflow, inexact}
    localparam int FLG_OVF = 2;
    localparam int FLG_UDF = 1;
    localparam int FLG_NX  = 0;

endpackage

// File: rtl/fp_round_decide.sv
// Rounding increment decision from mode, sign, mantissa LSB and guard/round/sticky.
module fp_round_decide
    import fp_pkg::*;
(
    input  logic [1:0] rm,
    input  logic       sign,
    input  logic       lsb,
    input  logic [2:0] grs,
    output logic       inc,
    output logic       inexact
);

    logic any;

    always_comb begin
        any     = |grs;
        inexact = any;
        inc     = 1'b0;
        case (rm)
            RM_RNE:  inc = grs[2] & (grs[1] | grs[0] | lsb);
            RM_RTZ:  inc = 1'b0;
            RM_RUP:  inc = ~sign & any;
            RM_RDN:  inc = sign & any;
            default: inc = 1'b0;
        endcase
    end

endmodule

// File: rtl/fp_round_pack.sv
// Two-stage round-and-pack: S1 registers the operand and increment decision,
// S2 applies the increment, classifies and holds the packed IEEE word.
module fp_round_pack
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W,
    localparam int W    = EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W-1:0] in_mant,
    input  logic [2:0]       in_grs,
    input  logic [1:0]       in_rm,
    input  logic             in_nan,
    input  logic             in_inf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic [2:0]       out_flags
);

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_MAX  = {{(EXP_W-1){1'b1}}, 1'b0};
    localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-2){1'b0}}};

    logic [2:1] vld_pipe;
    logic       s2_load;

    logic             s1_sign, s1_nan, s1_inf, s1_inc, s1_nx;
    logic [EXP_W-1:0] s1_exp;
    logic [MAN_W-1:0] s1_mant;
    logic [1:0]       s1_rm;

    logic in_inc, in_nx;

    fp_round_decide u_decide (
        .rm      (in_rm),
        .sign    (in_sign),
        .lsb     (in_mant[0]),
        .grs     (in_grs),
        .inc     (in_inc),
        .inexact (in_nx)
    );

    assign s2_load   = vld_pipe[1] & (~vld_pipe[2] | out_ready);
    assign in_ready  = ~vld_pipe[1] | s2_load;
    assign out_valid = vld_pipe[2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[1] <= 1'b0;
            s1_sign     <= 1'b0;
            s1_exp      <= '0;
            s1_mant     <= '0;
            s1_rm       <= RM_RNE;
            s1_nan      <= 1'b0;
            s1_inf      <= 1'b0;
            s1_inc      <= 1'b0;
            s1_nx       <= 1'b0;
        end else if (in_ready) begin
            vld_pipe[1] <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_exp  <= in_exp;
                s1_mant <= in_mant;
                s1_rm   <= in_rm;
                s1_nan  <= in_nan;
                s1_inf  <= in_inf;
                s1_inc  <= in_inc;
                s1_nx   <= in_nx;
            end
        end
    end

    // Increment, carry-out renormalisation and classification feeding S2.
    logic [MAN_W:0]   sum;
    logic [EXP_W:0]   exp_r;
    logic [MAN_W-2:0] frac_r;
    logic             ovf, to_inf;
    logic [W-1:0]     res_d;
    logic [2:0]       flags_d;

    always_comb begin
        sum    = {1'b0, s1_mant} + {{MAN_W{1'b0}}, s1_inc};
        exp_r  = {1'b0, s1_exp} + {{EXP_W{1'b0}}, sum[MAN_W]};
        frac_r = sum[MAN_W] ? sum[MAN_W-1:1] : sum[MAN_W-2:0];
        ovf    = exp_r >= {1'b0, EXP_ONES};
        case (s1_rm)
            RM_RNE:  to_inf = 1'b1;
            RM_RUP:  to_inf = ~s1_sign;
            RM_RDN:  to_inf = s1_sign;
            default: to_inf = 1'b0;
        endcase

        res_d   = {s1_sign, exp_r[EXP_W-1:0], frac_r};
        flags_d = 3'b000;
        flags_d[FLG_NX] = s1_nx;
        if (s1_nan) begin
            res_d   = QNAN;
            flags_d = 3'b000;
        end else if (s1_inf) begin
            res_d   = {s1_sign, EXP_ONES, {(MAN_W-1){1'b0}}};
            flags_d = 3'b000;
        end else if (!s1_mant[MAN_W-1]) begin
            res_d   = {s1_sign, {(W-1){1'b0}}};
            flags_d = 3'b000;
        end else if (s1_exp == '0) begin
            // No denormal support: flush to signed zero.
            res_d            = {s1_sign, {(W-1){1'b0}}};
            flags_d          = 3'b000;
            flags_d[FLG_UDF] = 1'b1;
            flags_d[FLG_NX]  = 1'b1;
        end else if (ovf) begin
            res_d            = to_inf ? {s1_sign, EXP_ONES, {(MAN_W-1){1'b0}}}
                                      : {s1_sign, EXP_MAX, {(MAN_W-1){1'b1}}};
            flags_d          = 3'b000;
            flags_d[FLG_OVF] = 1'b1;
            flags_d[FLG_NX]  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2] <= 1'b0;
            out_result  <= '0;
            out_flags   <= '0;
        end else if (s2_load) begin
            vld_pipe[2] <= 1'b1;
            out_result  <= res_d;
            out_flags   <= flags_d;
        end else if (out_ready) begin
            vld_pipe[2] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed bench for fp_round_pack: rounding/special vectors, backpressure ordering
// and reset flush, checked with immediate assertions.
module tb_fp_round_pack;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [10:0] in_exp = '0;
    logic [52:0] in_mant = '0;
    logic [2:0]  in_grs = '0;
    logic [1:0]  in_rm = '0;
    logic        in_nan = 1'b0;
    logic        in_inf = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic [2:0]  out_flags;

    int checks = 0;
    int errors = 0;

    localparam logic [52:0] ONES = 53'h1F_FFFF_FFFF_FFFF;
    localparam logic [52:0] HID  = 53'h10_0000_0000_0000;

    fp_round_pack dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_grs(in_grs),
        .in_rm(in_rm), .in_nan(in_nan), .in_inf(in_inf),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_one(input string tag, input logic sg, input logic [10:0] ex,
                           input logic [52:0] mn, input logic [2:0] grs, input logic [1:0] rm,
                           input logic nan, input logic inf,
                           input logic [63:0] exp_res, input logic [2:0] exp_fl);
        int cyc;
        @(negedge clk);
        out_ready = 1'b1;
        in_valid = 1'b1; in_sign = sg; in_exp = ex; in_mant = mn;
        in_grs = grs; in_rm = rm; in_nan = nan; in_inf = inf;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'd2);
        chk({tag, "_res"}, out_result, exp_res);
        chk({tag, "_flg"}, 64'(out_flags), 64'(exp_fl));
    endtask

    function automatic logic [63:0] beat_res(input int i);
        logic [10:0] e;
        e = 11'h3FF + 11'(i);
        return {1'b0, e, 52'(i)};
    endfunction

    initial begin
        int sent, recv, occ;
        logic       prev_stall;
        logic [63:0] prev_res;
        logic [2:0]  prev_fl;

        // Reset state
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_flags", 64'(out_flags), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // Directed rounding / classification vectors
        run_one("rne_tie_even", 0, 11'h3FF, HID, 3'b100, 2'b00, 0, 0, 64'h3FF0_0000_0000_0000, 3'b001);
        run_one("rne_tie_odd", 0, 11'h3FF, HID | 53'd1, 3'b100, 2'b00, 0, 0, 64'h3FF0_0000_0000_0002, 3'b001);
        run_one("carry_out", 0, 11'h3FF, ONES, 3'b110, 2'b00, 0, 0, 64'h4000_0000_0000_0000, 3'b001);
        run_one("ovf_rne", 1, 11'h7FE, ONES, 3'b100, 2'b00, 0, 0, 64'hFFF0_0000_0000_0000, 3'b101);
        run_one("near_max_rtz", 1, 11'h7FE, ONES, 3'b100, 2'b01, 0, 0, 64'hFFEF_FFFF_FFFF_FFFF, 3'b001);
        run_one("ovf_rup_neg", 1, 11'h7FF, HID, 3'b000, 2'b10, 0, 0, 64'hFFEF_FFFF_FFFF_FFFF, 3'b101);
        run_one("ovf_rdn_pos", 0, 11'h7FF, HID, 3'b000, 2'b11, 0, 0, 64'h7FEF_FFFF_FFFF_FFFF, 3'b101);
        run_one("ovf_rup_pos", 0, 11'h7FE, ONES, 3'b001, 2'b10, 0, 0, 64'h7FF0_0000_0000_0000, 3'b101);
        run_one("rup_pos", 0, 11'h3FF, HID, 3'b001, 2'b10, 0, 0, 64'h3FF0_0000_0000_0001, 3'b001);
        run_one("rdn_neg", 1, 11'h3FF, HID, 3'b001, 2'b11, 0, 0, 64'hBFF0_0000_0000_0001, 3'b001);
        run_one("rtz_exact", 0, 11'h3FF, HID | 53'd5, 3'b000, 2'b01, 0, 0, 64'h3FF0_0000_0000_0005, 3'b000);
        run_one("nan", 1, 11'h123, ONES, 3'b111, 2'b00, 1, 1, 64'h7FF8_0000_0000_0000, 3'b000);
        run_one("inf_neg", 1, 11'h123, ONES, 3'b111, 2'b00, 0, 1, 64'hFFF0_0000_0000_0000, 3'b000);
        run_one("zero_neg", 1, 11'h3FF, 53'd0, 3'b111, 2'b10, 0, 0, 64'h8000_0000_0000_0000, 3'b000);
        run_one("ftz_pos", 0, 11'h000, HID, 3'b000, 2'b00, 0, 0, 64'h0000_0000_0000_0000, 3'b011);
        run_one("ftz_neg", 1, 11'h000, ONES, 3'b100, 2'b00, 0, 0, 64'h8000_0000_0000_0000, 3'b011);

        // Backpressure: 8 beats, out_ready toggling every cycle
        @(negedge clk);
        sent = 0; recv = 0; prev_stall = 1'b0; prev_res = '0; prev_fl = '0;
        for (int cyc = 0; cyc < 60 && recv < 8; cyc++) begin
            out_ready = cyc[0];
            in_valid  = (sent < 8);
            in_sign = 1'b0; in_grs = 3'b000; in_rm = 2'b00; in_nan = 1'b0; in_inf = 1'b0;
            in_exp  = 11'h3FF + 11'(sent);
            in_mant = HID | 53'(sent);
            #1;
            occ = sent - recv;
            chk("bp_in_ready", 64'(in_ready), 64'(!(occ == 2 && !out_ready)));
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(out_valid), 64'd1);
                chk("bp_hold_res", out_result, prev_res);
                chk("bp_hold_flg", 64'(out_flags), 64'(prev_fl));
            end
            if (out_valid && out_ready) begin
                chk("bp_order", out_result, beat_res(recv));
                chk("bp_flags", 64'(out_flags), 64'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = out_result;
            prev_fl    = out_flags;
            if (out_valid && out_ready) recv++;
            if (in_valid && in_ready) sent++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("bp_recv_count", 64'(recv), 64'd8);
        out_ready = 1'b1;
        #1;
        chk("bp_drained", 64'(out_valid), 64'd0);

        // Reset with both stages full
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_exp = 11'h400 + 11'(i); in_mant = HID; in_grs = 3'b101;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("full_valid", 64'(out_valid), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_ready", 64'(in_ready), 64'd1);
        chk("rst_mid_res", out_result, 64'd0);
        chk("rst_mid_flg", 64'(out_flags), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_no_stale", 64'(out_valid), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
